// File: rtl/fetch_unit.sv
// fetch_unit: PC register and IF stage with one outstanding imem request,
// a one-entry decode-stall hold buffer and redirect kill tracking.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc_in,
    input  logic        redirect,
    input  logic        stall_id,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } if_id_t;

    state_t state, state_n;
    logic [31:0] pc_n;
    logic kill, kill_n;
    if_id_t hold_q, hold_n;
    logic hold_wr;
    if_id_t ifid_q, ifid_n;
    logic valid_n;
    logic acc;

    assign imem_addr = pc;
    assign pc4       = pc + 32'd4;
    assign id_instr  = ifid_q.instr;
    assign id_pc     = ifid_q.addr;

    always_comb begin
        acc      = !stall_id || !id_valid;
        state_n  = state;
        pc_n     = pc;
        kill_n   = kill;
        hold_n   = hold_q;
        hold_wr  = 1'b0;
        ifid_n   = ifid_q;
        // drain when decode takes the word, hold while it is stalled
        valid_n  = id_valid && stall_id;
        imem_req = 1'b0;
        unique case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                // a response still in flight from before a reset retires here
                if (imem_rvalid) kill_n = 1'b0;
                if (redirect) pc_n = npc_in;
                if (imem_ready) begin
                    state_n = S_WAIT;
                    if (redirect) kill_n = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_n = npc_in;
                    if (imem_rvalid) begin
                        kill_n  = 1'b0;
                        state_n = S_FETCH;
                    end else begin
                        kill_n = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_n = S_FETCH;
                    if (kill) begin
                        kill_n = 1'b0;
                    end else if (acc) begin
                        ifid_n  = '{instr: imem_rdata, addr: pc};
                        valid_n = 1'b1;
                        pc_n    = npc_in;
                    end else begin
                        hold_n  = '{instr: imem_rdata, addr: pc};
                        hold_wr = 1'b1;
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_n    = npc_in;
                    state_n = S_FETCH;
                end else if (acc) begin
                    ifid_n  = hold_q;
                    valid_n = 1'b1;
                    pc_n    = npc_in;
                    state_n = S_FETCH;
                end
            end
            default: state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_FETCH;
            pc       <= PC_RESET;
            kill     <= (state == S_WAIT);
            hold_q   <= '0;
            ifid_q   <= '0;
            id_valid <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            kill     <= kill_n;
            if (hold_wr) hold_q <= hold_n;
            ifid_q   <= ifid_n;
            id_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/decode/redirect stimulus checked against
// an instruction-stream model (next expected PC, response epochs, parked word).
module tb_fetch_unit;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc_in;
    logic        redirect;
    logic        stall_id;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_unit #(.PC_RESET(PC_RESET)) dut (
        .clk(clk),
        .reset(reset),
        .npc_in(npc_in),
        .redirect(redirect),
        .stall_id(stall_id),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .pc(pc),
        .pc4(pc4),
        .id_valid(id_valid),
        .id_instr(id_instr),
        .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] salt;

    // model state
    logic [31:0] exp_pc;
    int          epoch = 0;
    int          resp_epoch = 0;
    bit          outstanding = 0;
    bit          pending = 0;
    logic [31:0] out_addr;
    int          cnt = 0;
    int          cyc = 0;
    int          loads = 0;
    int          last_load = 0;
    int          last_gap = 0;

    // stimulus knobs
    int          p_stall = 0, p_redir = 0, p_ready = 100, p_rst = 0;
    int          lat_min = 1, lat_max = 1;
    int          force_stall = -1;
    int          redir_mode = 0;
    logic [31:0] redir_tgt = '0;
    bit          redir_fired = 0;
    int          rst_mode = 0;
    bit          rst_fired = 0;

    // inputs driven for, and outputs seen before, the coming edge
    logic        r_reset, r_redirect, r_stall, r_ready, r_rvalid;
    logic [31:0] r_npc;
    logic        o_req, o_idv;
    logic [31:0] o_addr, o_instr, o_idpc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        bit rv, do_rst, rd_now;
        logic [31:0] tgt;
        rv = 0;
        if (outstanding) begin
            if (cnt == 0) rv = 1;
            else cnt--;
        end
        imem_rvalid = rv;
        imem_rdata  = rv ? word_of(out_addr) : $urandom;
        do_rst = 0;
        if (rst_mode == 1) do_rst = 1;
        else if (rst_mode == 2 && outstanding && resp_epoch == epoch
                 && !rv && cnt >= 1) begin
            do_rst    = 1;
            rst_mode  = 0;
            rst_fired = 1;
        end else if (rst_mode == 0 && $urandom_range(999) < p_rst) do_rst = 1;
        reset = !do_rst;
        if (force_stall >= 0) stall_id = force_stall[0];
        else stall_id = ($urandom_range(99) < p_stall);
        imem_ready = !do_rst && !outstanding && ($urandom_range(99) < p_ready);
        rd_now = 0;
        if (redir_mode == 0) begin
            rd_now = ($urandom_range(99) < p_redir);
            tgt    = 32'h0000_4000 + ($urandom_range(1023) << 2);
        end else begin
            tgt = redir_tgt;
            case (redir_mode)
                1: rd_now = 1;
                2: rd_now = rv && resp_epoch == epoch;
                3: rd_now = outstanding && resp_epoch == epoch && !rv;
                4: rd_now = pending;
                5: rd_now = imem_req && imem_ready;
                default: rd_now = 0;
            endcase
            if (rd_now) begin
                redir_mode  = 0;
                redir_fired = 1;
            end
        end
        redirect = rd_now;
        npc_in   = rd_now ? tgt : exp_pc + 32'd4;
    endtask

    task automatic evaluate();
        bit resp_ok, acc, avail, exp_load, loaded;
        cyc++;
        if (!r_reset) begin
            if (r_rvalid) outstanding = 0;
            epoch++;
            pending = 0;
            exp_pc  = PC_RESET;
            chk("rst_id_valid", 32'(id_valid), 32'd0);
            chk("rst_id_instr", id_instr, 32'd0);
            chk("rst_id_pc", id_pc, 32'd0);
            chk("rst_req", 32'(imem_req), 32'd1);
            chk("rst_addr", imem_addr, PC_RESET);
        end else begin
            resp_ok = 0;
            if (r_rvalid) begin
                outstanding = 0;
                resp_ok     = (resp_epoch == epoch);
            end
            if (o_req && r_ready) begin
                chk("one_outstanding", 32'(outstanding), 32'd0);
                outstanding = 1;
                out_addr    = o_addr;
                resp_epoch  = epoch;
                cnt         = int'($urandom_range(lat_max, lat_min)) - 1;
            end
            exp_load = 0;
            if (r_redirect) begin
                epoch++;
                exp_pc  = r_npc;
                pending = 0;
            end else begin
                acc      = !r_stall || !o_idv;
                avail    = pending || resp_ok;
                exp_load = avail && acc;
                pending  = avail && !acc;
            end
            loaded = id_valid && (!o_idv || !r_stall);
            chk("load", 32'(loaded), 32'(exp_load));
            if (exp_load) begin
                chk("id_pc", id_pc, exp_pc);
                chk("id_instr", id_instr, word_of(exp_pc));
                exp_pc    = exp_pc + 32'd4;
                loads++;
                last_gap  = cyc - last_load;
                last_load = cyc;
            end
            if (o_idv && r_stall) begin
                chk("hold_valid", 32'(id_valid), 32'd1);
                chk("hold_instr", id_instr, o_instr);
                chk("hold_pc", id_pc, o_idpc);
            end
            if (o_req && !r_ready && !r_redirect) begin
                chk("req_stable", 32'(imem_req), 32'd1);
                chk("addr_stable", imem_addr, o_addr);
            end
        end
        chk("pc", pc, exp_pc);
        chk("pc4", pc4, exp_pc + 32'd4);
        if (imem_req) chk("imem_addr", imem_addr, exp_pc);
        if (pending || (outstanding && resp_epoch == epoch))
            chk("no_req", 32'(imem_req), 32'd0);
    endtask

    task automatic tick();
        drive();
        r_reset    = reset;
        r_redirect = redirect;
        r_stall    = stall_id;
        r_ready    = imem_ready;
        r_rvalid   = imem_rvalid;
        r_npc      = npc_in;
        o_req      = imem_req;
        o_addr     = imem_addr;
        o_idv      = id_valid;
        o_instr    = id_instr;
        o_idpc     = id_pc;
        @(posedge clk);
        #1;
        evaluate();
    endtask

    task automatic wait_loads(input int n, input int budget);
        int start;
        start = loads;
        for (int k = 0; k < budget && loads - start < n; k++) tick();
        chk("liveness", 32'(loads - start), 32'(n));
    endtask

    task automatic wait_redirect(input int budget);
        redir_fired = 0;
        for (int k = 0; k < budget && !redir_fired; k++) tick();
        chk("redirect_fired", 32'(redir_fired), 32'd1);
    endtask

    initial begin
        salt   = $urandom;
        exp_pc = PC_RESET;

        // reset, then free run with single-cycle memory
        rst_mode = 1;
        tick();
        tick();
        rst_mode = 0;
        wait_loads(6, 60);
        chk("throughput_gap", 32'(last_gap), 32'd2);

        // decode stall parks the returned word
        force_stall = 1;
        for (int k = 0; k < 20 && !pending; k++) tick();
        chk("parked", 32'(pending), 32'd1);
        for (int k = 0; k < 4; k++) tick();
        force_stall = 0;
        wait_loads(1, 1);
        force_stall = -1;
        wait_loads(2, 40);

        // redirect while waiting for data
        p_stall = 50;
        lat_min = 3;
        lat_max = 3;
        redir_tgt  = 32'h0000_3100;
        redir_mode = 3;
        wait_redirect(40);
        wait_loads(3, 80);

        // redirect in the same cycle as rvalid
        lat_min = 1;
        lat_max = 3;
        redir_tgt  = 32'h0000_3200;
        redir_mode = 2;
        wait_redirect(40);
        wait_loads(2, 60);

        // redirect while a word is parked
        force_stall = 1;
        for (int k = 0; k < 30 && !pending; k++) tick();
        redir_tgt  = 32'h0000_3200;
        redir_mode = 4;
        wait_redirect(10);
        force_stall = -1;
        wait_loads(2, 60);

        // redirect coinciding with a handshake in FETCH
        redir_tgt  = 32'h0000_3300;
        redir_mode = 5;
        wait_redirect(40);
        wait_loads(2, 60);

        // slow memory, then reset while waiting for data
        p_stall = 0;
        p_ready = 25;
        lat_min = 5;
        lat_max = 5;
        wait_loads(4, 200);
        rst_fired = 0;
        rst_mode  = 2;
        for (int k = 0; k < 60 && !rst_fired; k++) tick();
        rst_mode = 0;
        chk("reset_fired", 32'(rst_fired), 32'd1);
        wait_loads(3, 200);

        // PC wrap
        p_ready = 100;
        lat_min = 1;
        lat_max = 1;
        redir_tgt  = 32'hFFFF_FFFC;
        redir_mode = 1;
        tick();
        chk("wrap_pc4", pc4, 32'h0000_0000);
        wait_loads(3, 40);

        // random soak
        p_stall = 40;
        p_redir = 8;
        p_ready = 60;
        p_rst   = 3;
        lat_min = 1;
        lat_max = 6;
        for (int k = 0; k < 2000; k++) tick();
        p_redir = 0;
        p_rst   = 0;
        wait_loads(2, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
